usb_rx_ctrl: RTL and testbench
==============================

# usb_rx_ctrl

Parametrised receiver control unit for the USB bulk-endpoint RX path. It sequences SYNC/PID capture and validation, routes token, data and handshake packets to their CRC or EOP checks, and counts payload bytes against a configurable maximum packet size. Compared with the earlier fixed control unit, it adds length checking, a bus-idle timeout, a latched error code, and a done/acknowledge handshake toward the AHB-Lite side. It sits between the RX edge/shift/byte logic and the RX data buffer and status registers.

## Interface
- MAX_BYTES, 64, maximum data payload bytes, excluding PID and CRC16; legal range 1..1023
- TIMEOUT_CYCLES, 800, clk cycles without d_edge before an in-packet abort; must be ≥ 2
- CNT_W, $clog2(MAX_BYTES+3), derived width of byte_count
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- d_edge  in  1  D+/D- transition pulse
- byte_complete  in  1  one-cycle pulse per received byte
- eop_detected  in  1  EOP pulse
- sync_status  in  2  00 pending, 01 valid, 10/11 bad
- pid_status  in  3  000 pending, 001 token, 010 data, 011 handshake, others bad
- crc_status  in  2  00 pending, 01 pass, 10 fail, 11 treated as pending
- pkt_ack  in  1  consumer acknowledges the finished packet
- enable_timer, clear, load_sync, check_sync, load_pid, check_pid, load_data, crc_check_5, crc_check_16, load_error, load_done  out  1 each  Moore strobes to the datapath
- pkt_valid  out  1  packet finished; held until pkt_ack
- byte_count  out  CNT_W  bytes received after the PID, including CRC bytes
- err_code  out  3  000 none, 001 sync, 010 pid, 011 crc, 100 overflow, 101 timeout, 110 length

## Operation
- States: IDLE, SYNC, CHECK_SYNC, PID, CHECK_PID, TOKEN, DATA, HSHAKE, CHECK5, CHECK16, ERROR, DONE, HOLD.
- IDLE: goes to SYNC on d_edge. On that transition, byte_count and err_code clear to 0.
- SYNC: goes to CHECK_SYNC on byte_complete.
- CHECK_SYNC: 01 goes to PID; 00 stays; any other value goes to ERROR with err_code 001.
- PID: goes to CHECK_PID on byte_complete.
- CHECK_PID: 001 goes to TOKEN, 010 to DATA, 011 to HSHAKE; 000 stays; any other value goes to ERROR with err_code 010.
- TOKEN, DATA, HSHAKE: each byte_complete increments byte_count (saturating at 2^CNT_W−1).
- TOKEN on eop_detected: if count is 2, go to CHECK5; otherwise go to ERROR with err_code 110.
- DATA on eop_detected: if count ≥ 2, go to CHECK16; otherwise go to ERROR with err_code 110.
- DATA overflow: when the incremented count reaches MAX_BYTES+3, go to ERROR with err_code 100 immediately, without waiting for EOP.
- HSHAKE on eop_detected: if count is 0, go to DONE; otherwise go to ERROR with err_code 110.
- CHECK5, CHECK16: 01 goes to DONE; 10 goes to ERROR with err_code 011; other values stay.
- ERROR: goes to DONE after one cycle.
- DONE: goes to HOLD after one cycle.
- HOLD: goes to IDLE when pkt_ack is high. d_edge is ignored while in HOLD.
- Timeout counter:
  - Runs in SYNC, PID, TOKEN, DATA and HSHAKE.
  - Reset to 0 by d_edge and on every state change.
  - Reaching TIMEOUT_CYCLES−1 without a d_edge goes to ERROR with err_code 101.
- Priority within one cycle, highest first: overflow, eop, byte_complete, timeout.
  - byte_complete together with eop_detected: the byte is counted first, and the length check uses the new count.
- Output decode:
  - clear: IDLE only.
  - load_sync: SYNC. check_sync: CHECK_SYNC. load_pid: PID. check_pid: CHECK_PID.
  - load_data: TOKEN, DATA, CHECK5, CHECK16.
  - crc_check_5: CHECK5. crc_check_16: CHECK16.
  - load_error: ERROR. load_done: DONE. pkt_valid: HOLD.
  - enable_timer: every state except IDLE, CHECK5, CHECK16, ERROR, DONE, HOLD.

## Timing
- Reset values: state IDLE, clear=1, every other strobe 0, pkt_valid=0, byte_count=0, err_code=000, timeout counter 0.
- Reset is asynchronous at any point, including mid-packet. It takes effect immediately, and the first post-reset cycle is IDLE.
- All strobes are Moore outputs decoded from registered state, so they appear the cycle after the triggering input.
- byte_count and err_code are registered. Both are stable from DONE until the IDLE→SYNC transition of the next packet.
- load_done is exactly 1 cycle. pkt_valid rises the cycle after load_done.
- pkt_ack sampled in HOLD: state is IDLE on the next cycle. pkt_ack outside HOLD is ignored.
- Timeout latency: exactly TIMEOUT_CYCLES cycles from the last d_edge or state entry to load_error.

## Test plan
- Good DATA0 packet with 4 payload bytes and 2 CRC bytes, crc_status=01:
  - required: load_done pulses once, err_code=000, byte_count=6, pkt_valid held until pkt_ack, then IDLE.
- Token with 2 bytes and crc_status=10 -> CHECK5 reached, err_code=011, one load_error then one load_done.
- DATA with MAX_BYTES=8 and 11 bytes sent:
  - required: on the 11th byte_complete, ERROR with err_code=100, before any EOP.
- Handshake PID followed by 1 extra byte, then EOP -> err_code=110. The same packet with no extra byte -> err_code=000.
- d_edge stops in DATA -> load_error exactly TIMEOUT_CYCLES cycles later with err_code=101. Separately, n_rst pulsed mid-DATA -> all reset values, next packet handled normally.
- byte_complete and eop_detected in the same cycle on a token's 2nd byte -> CHECK5 entered; no length error.

Source files
------------

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: receive-side control unit for the USB bulk-endpoint RX path.
// Sequences SYNC/PID capture and validation, routes token/data/handshake
// packets to their CRC or EOP checks, counts post-PID bytes against
// MAX_BYTES, aborts an in-packet stall after TIMEOUT_CYCLES, latches an error
// code and holds pkt_valid until the consumer acknowledges.
//
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   d_edge                     line transition pulse (restarts the timeout)
//   byte_complete              one pulse per received byte
//   eop_detected               end-of-packet pulse
//   sync_status, pid_status    capture/decode results from the datapath
//   crc_status                 CRC5/CRC16 checker result
//   pkt_ack                    consumer acknowledge of a finished packet
//   enable_timer .. load_done  Moore strobes to the datapath
//   pkt_valid                  finished packet, held until pkt_ack
//   byte_count                 bytes after the PID, CRC bytes included
//   err_code                   latched result code of the last packet
module usb_rx_ctrl #(
  parameter int unsigned MAX_BYTES      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 800,
  parameter int unsigned CNT_W          = $clog2(MAX_BYTES + 3)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             d_edge,
  input  logic             byte_complete,
  input  logic             eop_detected,
  input  logic [1:0]       sync_status,
  input  logic [2:0]       pid_status,
  input  logic [1:0]       crc_status,
  input  logic             pkt_ack,
  output logic             enable_timer,
  output logic             clear,
  output logic             load_sync,
  output logic             check_sync,
  output logic             load_pid,
  output logic             check_pid,
  output logic             load_data,
  output logic             crc_check_5,
  output logic             crc_check_16,
  output logic             load_error,
  output logic             load_done,
  output logic             pkt_valid,
  output logic [CNT_W-1:0] byte_count,
  output logic [2:0]       err_code
);

  localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned OVF_CNT = MAX_BYTES + 3;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [2:0] ERR_NONE    = 3'b000;
  localparam logic [2:0] ERR_SYNC    = 3'b001;
  localparam logic [2:0] ERR_PID     = 3'b010;
  localparam logic [2:0] ERR_CRC     = 3'b011;
  localparam logic [2:0] ERR_OVF     = 3'b100;
  localparam logic [2:0] ERR_TIMEOUT = 3'b101;
  localparam logic [2:0] ERR_LEN     = 3'b110;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_CHECK_SYNC, S_PID, S_CHECK_PID, S_TOKEN, S_DATA,
    S_HSHAKE, S_CHECK5, S_CHECK16, S_ERROR, S_DONE, S_HOLD
  } state_e;

  typedef struct packed {
    logic enable_timer;
    logic clear;
    logic load_sync;
    logic check_sync;
    logic load_pid;
    logic check_pid;
    logic load_data;
    logic crc_check_5;
    logic crc_check_16;
    logic load_error;
    logic load_done;
    logic pkt_valid;
  } strb_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         err_q, err_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  strb_t              strb_q, strb_d;

  logic [CNT_W-1:0]   cnt_new;
  logic               ovf_hit;
  logic [TMR_W-1:0]   tmr_eff;
  logic               tmr_hit;
  logic               tmr_run;

  // Byte counter after this cycle's byte_complete, saturating at all-ones.
  // Overflow is judged on an extended sum so it still fires when MAX_BYTES+3
  // is a power of two and the stored count saturates one short of it.
  always_comb begin
    cnt_new = cnt_q;
    if (byte_complete && (cnt_q != CNT_MAX)) begin
      cnt_new = cnt_q + CNT_W'(1);
    end
    ovf_hit = byte_complete &&
              (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == (CNT_W + 1)'(OVF_CNT));
  end

  // A d_edge in the current cycle makes this cycle count zero, so the abort
  // lands exactly TIMEOUT_CYCLES after either the last edge or state entry.
  always_comb begin
    tmr_eff = d_edge ? '0 : tmr_q;
    tmr_hit = (tmr_eff == TMR_LAST);
    tmr_run = (state_q == S_SYNC) || (state_q == S_PID) ||
              (state_q == S_TOKEN) || (state_q == S_DATA) ||
              (state_q == S_HSHAKE);
  end

  // State register and packet bookkeeping.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next-state, byte count and error-code logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (d_edge) begin
          state_d = S_SYNC;
          cnt_d   = '0;
          err_d   = ERR_NONE;
        end
      end
      S_SYNC: begin
        if (byte_complete) begin
          state_d = S_CHECK_SYNC;
        end else if (tmr_hit) begin
          state_d = S_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_CHECK_SYNC: begin
        unique case (sync_status)
          2'b01:   state_d = S_PID;
          2'b00:   state_d = S_CHECK_SYNC;
          default: begin
            state_d = S_ERROR;
            err_d   = ERR_SYNC;
          end
        endcase
      end
      S_PID: begin
        if (byte_complete) begin
          state_d = S_CHECK_PID;
        end else if (tmr_hit) begin
          state_d = S_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_CHECK_PID: begin
        unique case (pid_status)
          3'b001:  state_d = S_TOKEN;
          3'b010:  state_d = S_DATA;
          3'b011:  state_d = S_HSHAKE;
          3'b000:  state_d = S_CHECK_PID;
          default: begin
            state_d = S_ERROR;
            err_d   = ERR_PID;
          end
        endcase
      end
      S_TOKEN: begin
        cnt_d = cnt_new;
        if (eop_detected) begin
          if (cnt_new == CNT_W'(2)) begin
            state_d = S_CHECK5;
          end else begin
            state_d = S_ERROR;
            err_d   = ERR_LEN;
          end
        end else if (!byte_complete && tmr_hit) begin
          state_d = S_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DATA: begin
        cnt_d = cnt_new;
        if (ovf_hit) begin
          state_d = S_ERROR;
          err_d   = ERR_OVF;
        end else if (eop_detected) begin
          if (cnt_new >= CNT_W'(2)) begin
            state_d = S_CHECK16;
          end else begin
            state_d = S_ERROR;
            err_d   = ERR_LEN;
          end
        end else if (!byte_complete && tmr_hit) begin
          state_d = S_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_HSHAKE: begin
        cnt_d = cnt_new;
        if (eop_detected) begin
          if (cnt_new == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
            err_d   = ERR_LEN;
          end
        end else if (!byte_complete && tmr_hit) begin
          state_d = S_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_CHECK5, S_CHECK16: begin
        if (crc_status == 2'b01) begin
          state_d = S_DONE;
        end else if (crc_status == 2'b10) begin
          state_d = S_ERROR;
          err_d   = ERR_CRC;
        end
      end
      S_ERROR: state_d = S_DONE;
      S_DONE:  state_d = S_HOLD;
      S_HOLD: begin
        if (pkt_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timeout counter: cleared on any state change and outside timed states;
  // holds at its terminal value if a byte_complete outranks the abort.
  always_comb begin
    tmr_d = '0;
    if (tmr_run && (state_d == state_q)) begin
      tmr_d = tmr_hit ? tmr_eff : tmr_eff + TMR_W'(1);
    end
  end

  // Strobe decode from the next state; registering it gives the same timing
  // as decoding the current state, with glitch-free outputs.
  always_comb begin
    strb_d = '0;
    unique case (state_d)
      S_IDLE:       strb_d.clear = 1'b1;
      S_SYNC: begin
        strb_d.load_sync    = 1'b1;
        strb_d.enable_timer = 1'b1;
      end
      S_CHECK_SYNC: begin
        strb_d.check_sync   = 1'b1;
        strb_d.enable_timer = 1'b1;
      end
      S_PID: begin
        strb_d.load_pid     = 1'b1;
        strb_d.enable_timer = 1'b1;
      end
      S_CHECK_PID: begin
        strb_d.check_pid    = 1'b1;
        strb_d.enable_timer = 1'b1;
      end
      S_TOKEN, S_DATA: begin
        strb_d.load_data    = 1'b1;
        strb_d.enable_timer = 1'b1;
      end
      S_HSHAKE:     strb_d.enable_timer = 1'b1;
      S_CHECK5: begin
        strb_d.load_data   = 1'b1;
        strb_d.crc_check_5 = 1'b1;
      end
      S_CHECK16: begin
        strb_d.load_data    = 1'b1;
        strb_d.crc_check_16 = 1'b1;
      end
      S_ERROR:      strb_d.load_error = 1'b1;
      S_DONE:       strb_d.load_done  = 1'b1;
      S_HOLD:       strb_d.pkt_valid  = 1'b1;
      default:      strb_d = '0;
    endcase
  end

  // Strobe register; reset matches the IDLE decode.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      strb_q       <= '0;
      strb_q.clear <= 1'b1;
    end else begin
      strb_q <= strb_d;
    end
  end

  assign enable_timer = strb_q.enable_timer;
  assign clear        = strb_q.clear;
  assign load_sync    = strb_q.load_sync;
  assign check_sync   = strb_q.check_sync;
  assign load_pid     = strb_q.load_pid;
  assign check_pid    = strb_q.check_pid;
  assign load_data    = strb_q.load_data;
  assign crc_check_5  = strb_q.crc_check_5;
  assign crc_check_16 = strb_q.crc_check_16;
  assign load_error   = strb_q.load_error;
  assign load_done    = strb_q.load_done;
  assign pkt_valid    = strb_q.pkt_valid;
  assign byte_count   = cnt_q;
  assign err_code     = err_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Testbench for usb_rx_ctrl: directed packets; each packet's expected result
// (err_code, byte_count, number of load_error pulses) is queued at issue time
// and a negedge monitor compares it whenever load_done appears.
module tb_usb_rx_ctrl;

  localparam int unsigned MAXB = 8;
  localparam int unsigned TO   = 800;
  localparam int unsigned CW   = $clog2(MAXB + 3);

  logic          clk;
  logic          n_rst;
  logic          d_edge, byte_complete, eop_detected, pkt_ack;
  logic [1:0]    sync_status, crc_status;
  logic [2:0]    pid_status;
  logic          enable_timer, clear, load_sync, check_sync, load_pid, check_pid;
  logic          load_data, crc_check_5, crc_check_16, load_error, load_done;
  logic          pkt_valid;
  logic [CW-1:0] byte_count;
  logic [2:0]    err_code;

  usb_rx_ctrl #(.MAX_BYTES(MAXB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .byte_complete(byte_complete),
    .eop_detected(eop_detected), .sync_status(sync_status),
    .pid_status(pid_status), .crc_status(crc_status), .pkt_ack(pkt_ack),
    .enable_timer(enable_timer), .clear(clear), .load_sync(load_sync),
    .check_sync(check_sync), .load_pid(load_pid), .check_pid(check_pid),
    .load_data(load_data), .crc_check_5(crc_check_5),
    .crc_check_16(crc_check_16), .load_error(load_error),
    .load_done(load_done), .pkt_valid(pkt_valid), .byte_count(byte_count),
    .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int err;
    int cnt;
    int nerr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   err_seen = 0;
  logic prev_done = 1'b0;

  function automatic void check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  function automatic void expect_pkt(input int err, input int cnt, input int nerr);
    exp_t e;
    e.err  = err;
    e.cnt  = cnt;
    e.nerr = nerr;
    sb_q.push_back(e);
  endfunction

  // Monitor: done is one cycle, pkt_valid follows it, result matches queue.
  always @(negedge clk) begin
    if (!n_rst) begin
      err_seen  = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        check("done_width", int'(load_done), 0);
        check("valid_after_done", int'(pkt_valid), 1);
      end
      if (load_error) err_seen++;
      if (load_done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_done: got load_done, expected none (t=%0t)", $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_err_code", int'(err_code), mon_e.err);
          check("sb_byte_count", int'(byte_count), mon_e.cnt);
          check("sb_error_pulses", err_seen, mon_e.nerr);
        end
        err_seen = 0;
      end
      prev_done = load_done;
    end
  end

  task automatic step(input logic de, input logic bc, input logic eop);
    d_edge        = de;
    byte_complete = bc;
    eop_detected  = eop;
    @(posedge clk);
    #1;
    d_edge        = 1'b0;
    byte_complete = 1'b0;
    eop_detected  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic bytes(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  // IDLE -> SYNC -> CHECK_SYNC -> PID -> CHECK_PID -> branch (or ERROR)
  task automatic head(input logic [1:0] ss, input logic [2:0] ps);
    sync_status = ss;
    pid_status  = ps;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    if (ss == 2'b01) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Wait (bounded) for HOLD, check pkt_valid is held, acknowledge, expect IDLE.
  task automatic finish_pkt(input string tag);
    for (int i = 0; i < 30 && !pkt_valid; i++) step(1'b0, 1'b0, 1'b0);
    check({tag, "_hold_reached"}, int'(pkt_valid), 1);
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    check({tag, "_valid_held"}, int'(pkt_valid), 1);
    pkt_ack = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    pkt_ack = 1'b0;
    check({tag, "_idle_clear"}, int'(clear), 1);
    check({tag, "_valid_drop"}, int'(pkt_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_rst = 1'b0;
    d_edge = 1'b0; byte_complete = 1'b0; eop_detected = 1'b0; pkt_ack = 1'b0;
    sync_status = 2'b00; pid_status = 3'b000; crc_status = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clear", int'(clear), 1);
    check("rst_enable_timer", int'(enable_timer), 0);
    check("rst_load_done", int'(load_done), 0);
    check("rst_pkt_valid", int'(pkt_valid), 0);
    check("rst_byte_count", int'(byte_count), 0);
    check("rst_err_code", int'(err_code), 0);
    n_rst = 1'b1;
    idle(2);
    check("idle_clear", int'(clear), 1);

    // Good DATA0: 4 payload + 2 CRC bytes
    crc_status = 2'b01;
    expect_pkt(0, 6, 0);
    head(2'b01, 3'b010);
    check("data_load_data", int'(load_data), 1);
    bytes(6);
    step(1'b0, 1'b0, 1'b1);
    check("data_crc16", int'(crc_check_16), 1);
    finish_pkt("good_data");

    // Token, 2 bytes, CRC5 fail
    crc_status = 2'b10;
    expect_pkt(3, 2, 1);
    head(2'b01, 3'b001);
    bytes(2);
    step(1'b0, 1'b0, 1'b1);
    check("tok_crc5", int'(crc_check_5), 1);
    finish_pkt("tok_crc_fail");

    // DATA overflow with MAX_BYTES=8: abort on the 11th byte, no EOP
    crc_status = 2'b01;
    expect_pkt(4, 11, 1);
    head(2'b01, 3'b010);
    bytes(10);
    check("ovf_not_yet", int'(load_error), 0);
    check("ovf_count10", int'(byte_count), 10);
    bytes(1);
    check("ovf_load_error", int'(load_error), 1);
    check("ovf_err_code", int'(err_code), 4);
    finish_pkt("overflow");

    // Handshake with one extra byte -> length error
    expect_pkt(6, 1, 1);
    head(2'b01, 3'b011);
    bytes(1);
    step(1'b0, 1'b0, 1'b1);
    finish_pkt("hs_extra");

    // Handshake clean -> DONE straight from EOP
    expect_pkt(0, 0, 0);
    head(2'b01, 3'b011);
    step(1'b0, 1'b0, 1'b1);
    check("hs_done_direct", int'(load_done), 1);
    finish_pkt("hs_clean");

    // Timeout in DATA: load_error exactly TO cycles after the last d_edge
    expect_pkt(5, 2, 1);
    head(2'b01, 3'b010);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n = 1;
    while (!load_error && n < int'(TO) + 20) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("timeout_latency", n, int'(TO));
    check("timeout_err_code", int'(err_code), 5);
    finish_pkt("timeout");

    // Asynchronous reset mid-DATA, then a normal packet
    head(2'b01, 3'b010);
    bytes(3);
    #2;
    n_rst = 1'b0;
    #1;
    check("midrst_clear", int'(clear), 1);
    check("midrst_load_data", int'(load_data), 0);
    check("midrst_enable_timer", int'(enable_timer), 0);
    check("midrst_byte_count", int'(byte_count), 0);
    check("midrst_err_code", int'(err_code), 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(1);
    check("postrst_clear", int'(clear), 1);
    expect_pkt(0, 4, 0);
    head(2'b01, 3'b010);
    bytes(4);
    step(1'b0, 1'b0, 1'b1);
    finish_pkt("post_reset_data");

    // Token: 2nd byte_complete coincides with EOP -> CHECK5, no length error
    expect_pkt(0, 2, 0);
    head(2'b01, 3'b001);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("same_cycle_crc5", int'(crc_check_5), 1);
    check("same_cycle_count", int'(byte_count), 2);
    finish_pkt("tok_same_cycle");

    // Bad SYNC and bad PID
    expect_pkt(1, 0, 1);
    head(2'b10, 3'b010);
    finish_pkt("bad_sync");
    expect_pkt(2, 0, 1);
    head(2'b01, 3'b101);
    finish_pkt("bad_pid");

    idle(3);
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
